sata_transport_pio_rx: RTL and testbench
========================================

// Module: sata_transport_pio_rx
// PURPOSE
//  Transport-layer PIO receive controller, downstream of the link-layer FIS stream. Parses PIO Setup FIS
//  (type 0x5F), latches direction/status/E_status/transfer count, then for device-to-host transfers
//  strips the Data FIS (type 0x46) header and forwards payload dwords to the user read stream,
//  counting down the byte count. Reports completion (E_status) or length/FIS-order errors to command layer.
// PARAMETERS
//  USER_W   8   tuser width; layout {drop,err,keep[3:0],sop,eop} (bit7..bit0)
//  CNT_W    16  transfer-count width in bytes (PIO Setup field is 16 b)
// PORTS
//  clk                  in   1       clock
//  rst_n                in   1       reset, asynchronous, active-low
//  s_axis_link_tdata    in   32      FIS dword from link layer
//  s_axis_link_tuser    in   USER_W  {drop,err,keep[3:0],sop,eop}
//  s_axis_link_tvalid   in   1       link data valid
//  s_axis_link_tready   out  1       ready to link
//  m_axis_pio_tdata     out  32      payload dword to user (D2H read data)
//  m_axis_pio_tkeep     out  4       byte enables of payload dword
//  m_axis_pio_tlast     out  1       last dword of PIO transfer
//  m_axis_pio_tvalid    out  1       payload valid
//  m_axis_pio_tready    in   1       user ready
//  pio_active           out  1       PIO transfer in progress
//  pio_dir_d2h          out  1       latched D bit (1 = device-to-host)
//  pio_xfer_cnt         out  CNT_W   latched transfer count (bytes)
//  pio_h2d_req          out  1       level: H2D data phase requested (D=0)
//  pio_h2d_done         in   1       pulse: H2D data FIS sent by command layer
//  pio_done             out  1       1-cycle pulse: transfer complete
//  pio_e_status         out  8       latched E_status, valid with pio_done
//  pio_err              out  1       1-cycle pulse: protocol/length error
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0. Reset mid-transfer aborts silently (no done/err pulse).
//  Fields (link byte order): dw0 [31:24] type, [21] D bit, [15:8] status; dw3 [7:0] E_status;
//   dw4 count = {tdata[23:16],tdata[31:24]}. Beat = tvalid&tready.
//  s_axis_link_tready = 1 in IDLE/SETUP/WAIT_DATA/FLUSH; in DATA = m_axis_pio_tready | ~m_axis_pio_tvalid.
//  FSM:
//   IDLE: beat with sop & type 0x5F -> SETUP (dword idx=1). Other FIS ignored.
//   SETUP: capture dw1..dw4; on dw4 beat (must carry eop) latch count, pio_active=1 next cycle.
//    D=1 -> WAIT_DATA; D=0 -> H2D. eop before dw4, or sop seen -> pio_err, IDLE.
//    count==0 -> pio_done next cycle, IDLE (no data phase).
//   WAIT_DATA: sop beat type 0x46 -> DATA (header dword dropped, not forwarded);
//    sop with other type -> pio_err, FLUSH (or IDLE if that beat has eop).
//   DATA: forward each payload beat through 1-deep output register; remaining -= popcount(keep).
//    tlast when remaining reaches 0 on that beat; keep forced so no byte past count is enabled.
//    After tlast accepted: pio_done pulse + pio_active=0, IDLE (extra dwords before eop -> FLUSH, no error).
//    eop with remaining>0 -> WAIT_DATA (next Data FIS continues count).
//    tuser drop|err on any beat -> pio_err pulse, FLUSH, transfer aborted.
//   H2D: pio_h2d_req=1; on pio_h2d_done -> pio_done pulse, IDLE.
//   FLUSH: consume until eop, then IDLE.
//  pio_done and pio_err never asserted same cycle; pio_err has priority. Output latency: 1 cycle link->m_axis.
//  remaining decrement saturates at 0 (underflow impossible).
//  pio_e_status/pio_dir_d2h/pio_xfer_cnt hold until next PIO Setup.
// STRUCTURE
//  sata_pkg: FIS_TYPE_PIO_SETUP=8'h5F, FIS_TYPE_DATA=8'h46, tuser bit index localparams,
//   pio_state_e enum {IDLE,SETUP,WAIT_DATA,DATA,H2D,FLUSH}.
//  Sub-module: sata_axis_reg_slice (1-deep skid/output register for m_axis_pio).
// TESTING
//  D2H 8 bytes: Setup D=1 cnt=8 E_status=0x50, Data FIS 2 dwords -> 2 beats, tlast on 2nd, pio_done, e_status=0x50.
//  Count 6: one Data FIS 2 dwords keep=F,F -> 2nd beat tkeep=4'b0011, tlast, done.
//  Split: cnt=16, two Data FIS x2 dwords -> 4 beats, tlast only on 4th; m_tready toggled 50% -> no loss/dup.
//  H2D: Setup D=0 cnt=512 -> pio_h2d_req=1; pio_h2d_done pulse -> pio_done, req=0.
//  Errors: Setup eop at dw2 -> pio_err; Data beat tuser.err=1 -> pio_err, FLUSH to eop, no pio_done.
//  Reset asserted mid-DATA -> all outputs 0 immediately, next Setup accepted normally.

Source files
------------

// File: rtl/sata_pkg.sv
// Shared definitions for the SATA transport-layer PIO receive path:
// FIS type codes, link tuser bit positions, PIO FSM states and byte-enable helpers.
package sata_pkg;

    localparam logic [7:0] FIS_TYPE_PIO_SETUP = 8'h5F;
    localparam logic [7:0] FIS_TYPE_DATA      = 8'h46;

    // tuser layout {drop, err, keep[3:0], sop, eop}
    localparam int unsigned TU_EOP  = 0;
    localparam int unsigned TU_SOP  = 1;
    localparam int unsigned TU_KEEP = 2;
    localparam int unsigned TU_ERR  = 6;
    localparam int unsigned TU_DROP = 7;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_DATA,
        DATA,
        H2D,
        FLUSH
    } pio_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] k);
        return {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
    endfunction

    // Byte enables covering the first n bytes of a dword (n clipped to 4 by the caller).
    function automatic logic [3:0] keep_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 4'h0;
            3'd1:    return 4'h1;
            3'd2:    return 4'h3;
            3'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/sata_axis_reg_slice.sv
// One-deep AXI-Stream output register: accepts a new word whenever it is empty
// or its current word is being taken downstream in the same cycle.
module sata_axis_reg_slice #(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = i_ready | ~r_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sata_transport_pio_rx.sv
// Transport-layer PIO receive controller: parses PIO Setup FIS, then strips Data FIS
// headers and forwards D2H payload to the user stream while counting down the byte count.
module sata_transport_pio_rx
    import sata_pkg::*;
#(
    parameter int unsigned USER_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       s_axis_link_tdata,
    input  logic [USER_W-1:0] s_axis_link_tuser,
    input  logic              s_axis_link_tvalid,
    output logic              s_axis_link_tready,
    output logic [31:0]       m_axis_pio_tdata,
    output logic [3:0]        m_axis_pio_tkeep,
    output logic              m_axis_pio_tlast,
    output logic              m_axis_pio_tvalid,
    input  logic              m_axis_pio_tready,
    output logic              pio_active,
    output logic              pio_dir_d2h,
    output logic [CNT_W-1:0]  pio_xfer_cnt,
    output logic              pio_h2d_req,
    input  logic              pio_h2d_done,
    output logic              pio_done,
    output logic [7:0]        pio_e_status,
    output logic              pio_err
);

    pio_state_e r_state, w_state_nxt;

    logic [2:0]       r_idx;
    logic             r_dir_pend;
    logic [7:0]       r_es_pend;
    logic             r_dir;
    logic [7:0]       r_es;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rem;
    logic             r_active;
    logic             r_done;
    logic             r_err;

    logic             w_beat, w_sop, w_eop, w_bad;
    logic [3:0]       w_keep, w_keep_out;
    logic [7:0]       w_type;
    logic [2:0]       w_pop, w_rem_clip;
    logic [CNT_W-1:0] w_cnt_in, w_rem_nxt;
    logic             w_last_beat;
    logic             w_start, w_commit, w_fwd, w_last, w_err;
    logic             w_zero_done, w_h2d_fin, w_done;
    logic             w_slice_rdy;
    logic [36:0]      w_slice_out;

    assign w_sop      = s_axis_link_tuser[TU_SOP];
    assign w_eop      = s_axis_link_tuser[TU_EOP];
    assign w_bad      = s_axis_link_tuser[TU_DROP] | s_axis_link_tuser[TU_ERR];
    assign w_keep     = s_axis_link_tuser[TU_KEEP +: 4];
    assign w_type     = s_axis_link_tdata[31:24];
    assign w_cnt_in   = CNT_W'({s_axis_link_tdata[23:16], s_axis_link_tdata[31:24]});

    assign s_axis_link_tready = (r_state == DATA) ? w_slice_rdy : 1'b1;
    assign w_beat             = s_axis_link_tvalid & s_axis_link_tready;

    // Count-down arithmetic: the beat that exhausts the count is last and its keep is trimmed.
    assign w_pop       = popcount4(w_keep);
    assign w_rem_clip  = (r_rem >= CNT_W'(4)) ? 3'd4 : r_rem[2:0];
    assign w_keep_out  = w_keep & keep_mask(w_rem_clip);
    assign w_last_beat = (CNT_W'(w_pop) >= r_rem);
    assign w_rem_nxt   = w_last_beat ? '0 : (r_rem - CNT_W'(w_pop));

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        w_fwd       = 1'b0;
        w_last      = 1'b0;
        w_err       = 1'b0;
        w_zero_done = 1'b0;
        w_h2d_fin   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_beat && w_sop && !w_bad && w_type == FIS_TYPE_PIO_SETUP) begin
                    if (w_eop) begin
                        w_err = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                if (w_beat) begin
                    if (w_sop) begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (w_bad || (r_idx != 3'd4 && w_eop) || (r_idx == 3'd4 && !w_eop)) begin
                        w_err       = 1'b1;
                        w_state_nxt = w_eop ? IDLE : FLUSH;
                    end else if (r_idx == 3'd4) begin
                        w_commit = 1'b1;
                        if (w_cnt_in == '0) begin
                            w_zero_done = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = r_dir_pend ? WAIT_DATA : H2D;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                if (w_beat && w_sop) begin
                    if (w_bad || w_type != FIS_TYPE_DATA) begin
                        w_err       = 1'b1;
                        w_state_nxt = w_eop ? IDLE : FLUSH;
                    end else if (!w_eop) begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_beat) begin
                    if (w_bad || w_sop) begin
                        w_err       = 1'b1;
                        w_state_nxt = w_eop ? IDLE : FLUSH;
                    end else begin
                        w_fwd = 1'b1;
                        w_last = w_last_beat;
                        if (w_last_beat)
                            w_state_nxt = w_eop ? IDLE : FLUSH;
                        else if (w_eop)
                            w_state_nxt = WAIT_DATA;
                    end
                end
            end
            H2D: begin
                if (pio_h2d_done) begin
                    w_h2d_fin   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (w_beat && w_eop)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // D2H completion is taken at the user handshake of tlast, not at the link beat.
    assign w_done = w_zero_done | w_h2d_fin |
                    (m_axis_pio_tvalid & m_axis_pio_tready & m_axis_pio_tlast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_dir_pend <= 1'b0;
            r_es_pend  <= '0;
            r_dir      <= 1'b0;
            r_es       <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done & ~w_err;
            r_err   <= w_err;
            if (w_start) begin
                r_idx      <= 3'd1;
                r_dir_pend <= s_axis_link_tdata[21];
            end
            if (r_state == SETUP && w_beat) begin
                r_idx <= r_idx + 3'd1;
                if (r_idx == 3'd3)
                    r_es_pend <= s_axis_link_tdata[7:0];
            end
            if (w_commit) begin
                r_dir <= r_dir_pend;
                r_es  <= r_es_pend;
                r_cnt <= w_cnt_in;
                r_rem <= w_cnt_in;
            end
            if (w_fwd)
                r_rem <= w_rem_nxt;
            if (w_err || w_done)
                r_active <= 1'b0;
            if (w_commit && w_cnt_in != '0)
                r_active <= 1'b1;
        end
    end

    sata_axis_reg_slice #(
        .W(37)
    ) u_out_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  ({w_keep_out, w_last, s_axis_link_tdata}),
        .i_valid (w_fwd),
        .o_ready (w_slice_rdy),
        .o_data  (w_slice_out),
        .o_valid (m_axis_pio_tvalid),
        .i_ready (m_axis_pio_tready)
    );

    assign m_axis_pio_tkeep = w_slice_out[36:33];
    assign m_axis_pio_tlast = w_slice_out[32];
    assign m_axis_pio_tdata = w_slice_out[31:0];

    assign pio_active   = r_active;
    assign pio_dir_d2h  = r_dir;
    assign pio_xfer_cnt = r_cnt;
    assign pio_h2d_req  = (r_state == H2D);
    assign pio_done     = r_done;
    assign pio_e_status = r_es;
    assign pio_err      = r_err;

endmodule

// File: tb/tb_sata_transport_pio_rx.sv
// Directed bench for sata_transport_pio_rx: a table of per-cycle link/user stimulus with
// expected outputs, plus hand sequences for backpressure and mid-transfer reset.
module tb_sata_transport_pio_rx;

    localparam logic [7:0] U_SOP = 8'h3E;
    localparam logic [7:0] U_MID = 8'h3C;
    localparam logic [7:0] U_EOP = 8'h3D;
    localparam logic [7:0] U_ERR = 8'h7C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata;
    logic [7:0]  s_tuser;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        pio_active;
    logic        pio_dir_d2h;
    logic [15:0] pio_xfer_cnt;
    logic        pio_h2d_req;
    logic        pio_h2d_done;
    logic        pio_done;
    logic [7:0]  pio_e_status;
    logic        pio_err;

    always #5 clk = ~clk;

    sata_transport_pio_rx #(
        .USER_W(8),
        .CNT_W (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_link_tdata  (s_tdata),
        .s_axis_link_tuser  (s_tuser),
        .s_axis_link_tvalid (s_tvalid),
        .s_axis_link_tready (s_tready),
        .m_axis_pio_tdata   (m_tdata),
        .m_axis_pio_tkeep   (m_tkeep),
        .m_axis_pio_tlast   (m_tlast),
        .m_axis_pio_tvalid  (m_tvalid),
        .m_axis_pio_tready  (m_tready),
        .pio_active         (pio_active),
        .pio_dir_d2h        (pio_dir_d2h),
        .pio_xfer_cnt       (pio_xfer_cnt),
        .pio_h2d_req        (pio_h2d_req),
        .pio_h2d_done       (pio_h2d_done),
        .pio_done           (pio_done),
        .pio_e_status       (pio_e_status),
        .pio_err            (pio_err)
    );

    typedef struct {
        logic [31:0] tdata;
        logic [7:0]  tuser;
        logic        tvalid;
        logic        h2d;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic        ea;
        logic        edn;
        logic        eer;
        logic        ehr;
        logic        lat;
        logic [7:0]  ees;
        logic        edir;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   t1_lo, t1_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic row(input logic [31:0] d, input logic [7:0] u, input logic v, input logic h2d,
                       input logic ev, input logic [31:0] ed, input logic [3:0] ek, input logic el,
                       input logic ea, input logic edn, input logic eer, input logic ehr);
        vec_t r;
        r.tdata = d;  r.tuser = u;  r.tvalid = v;  r.h2d = h2d;
        r.ev = ev;    r.ed = ed;    r.ek = ek;     r.el = el;
        r.ea = ea;    r.edn = edn;  r.eer = eer;   r.ehr = ehr;
        r.lat = 1'b0; r.ees = '0;   r.edir = 1'b0; r.ecnt = '0;
        tbl.push_back(r);
    endtask

    task automatic idle(input logic h2d, input logic ea, input logic edn, input logic eer, input logic ehr);
        row('0, '0, '0, h2d, '0, '0, '0, '0, ea, edn, eer, ehr);
    endtask

    // Five-dword PIO Setup; expectations given apply after the final (dw4) beat.
    task automatic setup5(input logic [31:0] dw0, input logic [7:0] es, input logic [31:0] dw4,
                          input logic ea, input logic edn, input logic ehr);
        row(dw0,         U_SOP, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        row('0,          U_MID, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        row('0,          U_MID, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        row({24'h0, es}, U_MID, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        row(dw4,         U_EOP, '1, '0, '0, '0, '0, '0, ea, edn, '0, ehr);
    endtask

    task automatic lat(input logic [7:0] es, input logic dir, input logic [15:0] cnt);
        int n;
        n = tbl.size() - 1;
        tbl[n].lat  = 1'b1;
        tbl[n].ees  = es;
        tbl[n].edir = dir;
        tbl[n].ecnt = cnt;
    endtask

    task automatic apply_row(input int i);
        @(negedge clk);
        s_tdata      = tbl[i].tdata;
        s_tuser      = tbl[i].tuser;
        s_tvalid     = tbl[i].tvalid;
        m_tready     = 1'b1;
        pio_h2d_done = tbl[i].h2d;
        @(posedge clk);
        #1;
        check($sformatf("row%0d m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].ev));
        if (tbl[i].ev) begin
            check($sformatf("row%0d m_tdata", i), m_tdata, tbl[i].ed);
            check($sformatf("row%0d m_tkeep", i), 32'(m_tkeep), 32'(tbl[i].ek));
            check($sformatf("row%0d m_tlast", i), 32'(m_tlast), 32'(tbl[i].el));
        end
        check($sformatf("row%0d pio_active", i), 32'(pio_active), 32'(tbl[i].ea));
        check($sformatf("row%0d pio_done", i), 32'(pio_done), 32'(tbl[i].edn));
        check($sformatf("row%0d pio_err", i), 32'(pio_err), 32'(tbl[i].eer));
        check($sformatf("row%0d pio_h2d_req", i), 32'(pio_h2d_req), 32'(tbl[i].ehr));
        if (tbl[i].lat) begin
            check($sformatf("row%0d pio_e_status", i), 32'(pio_e_status), 32'(tbl[i].ees));
            check($sformatf("row%0d pio_dir_d2h", i), 32'(pio_dir_d2h), 32'(tbl[i].edir));
            check($sformatf("row%0d pio_xfer_cnt", i), 32'(pio_xfer_cnt), 32'(tbl[i].ecnt));
        end
        s_tvalid     = 1'b0;
        pio_h2d_done = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [7:0] u);
        @(negedge clk);
        s_tdata  = d;
        s_tuser  = u;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, " m_tdata"}, m_tdata, 32'd0);
        check({tag, " m_tkeep"}, 32'(m_tkeep), 32'd0);
        check({tag, " m_tlast"}, 32'(m_tlast), 32'd0);
        check({tag, " pio_active"}, 32'(pio_active), 32'd0);
        check({tag, " pio_dir_d2h"}, 32'(pio_dir_d2h), 32'd0);
        check({tag, " pio_xfer_cnt"}, 32'(pio_xfer_cnt), 32'd0);
        check({tag, " pio_h2d_req"}, 32'(pio_h2d_req), 32'd0);
        check({tag, " pio_done"}, 32'(pio_done), 32'd0);
        check({tag, " pio_e_status"}, 32'(pio_e_status), 32'd0);
        check({tag, " pio_err"}, 32'(pio_err), 32'd0);
        check({tag, " s_tready"}, 32'(s_tready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sd[11];
        logic [7:0]  su[11];
        logic [31:0] pe[4];
        logic [31:0] rx_d[4];
        logic [3:0]  rx_k[4];
        logic        rx_l[4];
        int          idx, got, dones, errs;

        s_tdata = '0; s_tuser = '0; s_tvalid = 1'b0;
        m_tready = 1'b0; pio_h2d_done = 1'b0;

        // D2H 8 bytes, E_status 0x50
        t1_lo = tbl.size();
        setup5(32'h5F20_5000, 8'h50, 32'h0800_0000, '1, '0, '0);
        row(32'h4600_0000, U_SOP, '1, '0, '0, '0, '0, '0, '1, '0, '0, '0);
        row(32'hAAAA_0001, U_MID, '1, '0, '1, 32'hAAAA_0001, 4'hF, '0, '1, '0, '0, '0);
        row(32'hBBBB_0002, U_EOP, '1, '0, '1, 32'hBBBB_0002, 4'hF, '1, '1, '0, '0, '0);
        idle('0, '0, '1, '0, '0);
        idle('0, '0, '0, '0, '0);
        lat(8'h50, 1'b1, 16'd8);
        t1_hi = tbl.size();

        // Count 6: second dword trimmed to two bytes
        setup5(32'h5F20_5000, 8'h51, 32'h0600_0000, '1, '0, '0);
        row(32'h4600_0000, U_SOP, '1, '0, '0, '0, '0, '0, '1, '0, '0, '0);
        row(32'h1111_1111, U_MID, '1, '0, '1, 32'h1111_1111, 4'hF, '0, '1, '0, '0, '0);
        row(32'h2222_2222, U_EOP, '1, '0, '1, 32'h2222_2222, 4'h3, '1, '1, '0, '0, '0);
        idle('0, '0, '1, '0, '0);
        idle('0, '0, '0, '0, '0);
        lat(8'h51, 1'b1, 16'd6);

        // H2D, count 512
        setup5(32'h5F00_5000, 8'h52, 32'h0002_0000, '1, '0, '1);
        idle('0, '1, '0, '0, '1);
        idle('1, '0, '1, '0, '0);
        idle('0, '0, '0, '0, '0);
        lat(8'h52, 1'b0, 16'd512);

        // Setup truncated at dw2: error, latched fields untouched
        row(32'h5F20_5000, U_SOP, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        row('0,            U_MID, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        row('0,            U_EOP, '1, '0, '0, '0, '0, '0, '0, '0, '1, '0);
        idle('0, '0, '0, '0, '0);
        lat(8'h52, 1'b0, 16'd512);

        // Data beat with tuser.err: error, flush to eop, no done
        setup5(32'h5F20_5000, 8'h53, 32'h0800_0000, '1, '0, '0);
        row(32'h4600_0000, U_SOP, '1, '0, '0, '0, '0, '0, '1, '0, '0, '0);
        row(32'hAAAA_0001, U_MID, '1, '0, '1, 32'hAAAA_0001, 4'hF, '0, '1, '0, '0, '0);
        row(32'hDEAD_BEEF, U_ERR, '1, '0, '0, '0, '0, '0, '0, '0, '1, '0);
        row(32'hCCCC_0003, U_MID, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        row(32'hDDDD_0004, U_EOP, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        idle('0, '0, '0, '0, '0);

        // Count 0: immediate done, no data phase
        setup5(32'h5F20_5000, 8'h54, 32'h0000_0000, '0, '1, '0);
        idle('0, '0, '0, '0, '0);
        lat(8'h54, 1'b1, 16'd0);

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply_row(i);

        // Split transfer, 16 bytes over two Data FIS, user ready toggling
        sd = '{32'h5F20_5000, 32'h0, 32'h0, 32'h0000_0055, 32'h1000_0000,
               32'h4600_0000, 32'h1234_0000, 32'h1234_0001,
               32'h4600_0000, 32'h1234_0002, 32'h1234_0003};
        su = '{U_SOP, U_MID, U_MID, U_MID, U_EOP, U_SOP, U_MID, U_EOP, U_SOP, U_MID, U_EOP};
        pe = '{32'h1234_0000, 32'h1234_0001, 32'h1234_0002, 32'h1234_0003};
        idx = 0; got = 0; dones = 0; errs = 0;
        for (int k = 0; k < 4; k++) begin
            rx_d[k] = '0; rx_k[k] = '0; rx_l[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (idx < 11) begin
                s_tdata  = sd[idx];
                s_tuser  = su[idx];
                s_tvalid = 1'b1;
            end else begin
                s_tvalid = 1'b0;
            end
            m_tready = ((cyc % 2) == 1);
            #1;
            if (m_tvalid && m_tready) begin
                if (got < 4) begin
                    rx_d[got] = m_tdata;
                    rx_k[got] = m_tkeep;
                    rx_l[got] = m_tlast;
                end
                got++;
            end
            if (s_tvalid && s_tready)
                idx++;
            if (pio_done) dones++;
            if (pio_err) errs++;
            @(posedge clk);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        check("split link beats consumed", 32'(idx), 32'd11);
        check("split beats received", 32'(got), 32'd4);
        check("split done pulses", 32'(dones), 32'd1);
        check("split err pulses", 32'(errs), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("split beat%0d data", k), rx_d[k], pe[k]);
            check($sformatf("split beat%0d keep", k), 32'(rx_k[k]), 32'hF);
            check($sformatf("split beat%0d last", k), 32'(rx_l[k]), (k == 3) ? 32'd1 : 32'd0);
        end
        check("split e_status", 32'(pio_e_status), 32'h55);
        check("split xfer_cnt", 32'(pio_xfer_cnt), 32'd16);

        // Reset mid-DATA with the output register held full
        m_tready = 1'b1;
        drive_beat(32'h5F20_5000, U_SOP);
        drive_beat(32'h0, U_MID);
        drive_beat(32'h0, U_MID);
        drive_beat(32'h0000_0066, U_MID);
        drive_beat(32'h1000_0000, U_EOP);
        drive_beat(32'h4600_0000, U_SOP);
        m_tready = 1'b0;
        drive_beat(32'h7777_0000, U_MID);
        check("stall m_tvalid", 32'(m_tvalid), 32'd1);
        check("stall m_tdata", m_tdata, 32'h7777_0000);
        check("stall pio_active", 32'(pio_active), 32'd1);
        check("stall s_tready", 32'(s_tready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_tready = 1'b1;

        for (int i = t1_lo; i < t1_hi; i++)
            apply_row(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
